// File: rtl/usart_tx_peripheral.sv
// usart_tx_peripheral: memory-mapped async serial transmitter (TXREG/TXSTA/SPBRG), one-byte holding buffer.
// Optional ninth data bit (TX9/TX9D, NINTH state) is compiled in with `define USART_TX_NINTH_BIT_EN.
module usart_tx_peripheral #(
  parameter logic [8:0] TXREG_ADDR = 9'h019,
  parameter logic [8:0] TXSTA_ADDR = 9'h098,
  parameter logic [8:0] SPBRG_ADDR = 9'h099
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] addr,
  input  logic [7:0] data_in,
  input  logic       wr_en,
  output logic [7:0] data_out,
  output logic       interrupt_strobe,
  output logic       tx
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
`ifdef USART_TX_NINTH_BIT_EN
    NINTH = 3'd3,
`endif
    STOP  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       txen_q, txen_d, brgh_q, brgh_d;
  logic [7:0] spbrg_q, spbrg_d, hold_q, hold_d, tsr_q, tsr_d;
  logic       full_q, full_d, strobe_q, strobe_d, tx_q, tx_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] brg_q, brg_d, rate_q, rate_d;
  logic [5:0] sub_q, sub_d;
  logic       hs_q, hs_d;
  logic       tx9, tx9d, trmt;
  logic       txsta_wr, txreg_wr, spbrg_wr, txen_fall, txen_rise;
  logic       tick, bit_end, xfer, restart;

  assign txsta_wr  = wr_en && (addr == TXSTA_ADDR);
  assign txreg_wr  = wr_en && (addr == TXREG_ADDR);
  assign spbrg_wr  = wr_en && (addr == SPBRG_ADDR);
  assign txen_fall = txsta_wr && txen_q && !data_in[5];
  assign txen_rise = txsta_wr && !txen_q && data_in[5];
  // rate_q/hs_q hold the divisor in force for the current bit; new SPBRG/BRGH apply at the boundary
  assign tick      = (brg_q == 8'd0);
  assign bit_end   = tick && (sub_q == (hs_q ? 6'd15 : 6'd63));
  assign trmt      = (state_q == IDLE);

`ifdef USART_TX_NINTH_BIT_EN
  logic tx9_q, tx9d_q, ninth_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx9_q   <= 1'b0;
      tx9d_q  <= 1'b0;
      ninth_q <= 1'b0;
    end else begin
      if (txsta_wr) begin
        tx9_q  <= data_in[6];
        tx9d_q <= data_in[0];
      end
      if (xfer) ninth_q <= tx9d_q;
    end
  end
  assign tx9  = tx9_q;
  assign tx9d = tx9d_q;
`else
  assign tx9  = 1'b0;
  assign tx9d = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    tsr_d   = tsr_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    brg_d   = brg_q;
    sub_d   = sub_q;
    rate_d  = rate_q;
    hs_d    = hs_q;
    xfer    = 1'b0;
    restart = 1'b0;
    if (state_q != IDLE) begin
      if (tick) begin
        brg_d = rate_q;
        sub_d = sub_q + 6'd1;
      end else begin
        brg_d = brg_q - 8'd1;
      end
    end
    case (state_q)
      IDLE:  xfer = full_q && txen_q;
      START: if (bit_end) begin
        state_d = DATA;
        tx_d    = tsr_q[0];
        bit_d   = 3'd0;
        restart = 1'b1;
      end
      DATA: if (bit_end) begin
        restart = 1'b1;
        if (bit_q == 3'd7) begin
`ifdef USART_TX_NINTH_BIT_EN
          if (tx9) begin
            state_d = NINTH;
            tx_d    = ninth_q;
          end else
`endif
          begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          tsr_d = {1'b0, tsr_q[7:1]};
          tx_d  = tsr_q[1];
          bit_d = bit_q + 3'd1;
        end
      end
`ifdef USART_TX_NINTH_BIT_EN
      NINTH: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
        restart = 1'b1;
      end
`endif
      STOP: if (bit_end) begin
        restart = 1'b1;
        if (full_q && txen_q) xfer = 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      state_d = START;
      tsr_d   = hold_q;
      tx_d    = 1'b0;
      restart = 1'b1;
    end
    if (restart) begin
      brg_d  = spbrg_q;
      sub_d  = 6'd0;
      rate_d = spbrg_q;
      hs_d   = brgh_q;
    end
    // disabling the transmitter aborts the frame outright and suppresses any pending transfer
    if (txen_fall) begin
      xfer    = 1'b0;
      state_d = IDLE;
      tx_d    = 1'b1;
      brg_d   = 8'd0;
      sub_d   = 6'd0;
    end
  end

  always_comb begin
    txen_d  = txen_q;
    brgh_d  = brgh_q;
    spbrg_d = spbrg_q;
    hold_d  = hold_q;
    full_d  = full_q;
    if (txsta_wr) begin
      txen_d = data_in[5];
      brgh_d = data_in[2];
    end
    if (spbrg_wr) spbrg_d = data_in;
    if (xfer) full_d = 1'b0;
    // a write landing on a transfer cycle refills the buffer after the old byte moves out
    if (txreg_wr && txen_q) begin
      hold_d = data_in;
      full_d = 1'b1;
    end
    if (txen_fall) full_d = 1'b0;
  end

  assign strobe_d = xfer || txen_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      txen_q   <= 1'b0;
      brgh_q   <= 1'b0;
      spbrg_q  <= 8'h00;
      hold_q   <= 8'h00;
      full_q   <= 1'b0;
      tsr_q    <= 8'h00;
      bit_q    <= 3'd0;
      brg_q    <= 8'd0;
      sub_q    <= 6'd0;
      rate_q   <= 8'd0;
      hs_q     <= 1'b0;
      strobe_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      txen_q   <= txen_d;
      brgh_q   <= brgh_d;
      spbrg_q  <= spbrg_d;
      hold_q   <= hold_d;
      full_q   <= full_d;
      tsr_q    <= tsr_d;
      bit_q    <= bit_d;
      brg_q    <= brg_d;
      sub_q    <= sub_d;
      rate_q   <= rate_d;
      hs_q     <= hs_d;
      strobe_q <= strobe_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (addr == TXSTA_ADDR)      data_out = {1'b0, tx9, txen_q, 2'b00, brgh_q, trmt, tx9d};
    else if (addr == SPBRG_ADDR) data_out = spbrg_q;
  end

  assign interrupt_strobe = strobe_q;
  assign tx               = tx_q;
endmodule

// File: tb/tb_usart_tx_peripheral.sv
// Bench for usart_tx_peripheral: directed scenarios plus random frames checked against a bit-time frame model.
module tb_usart_tx_peripheral;
  localparam logic [8:0] A_TXREG = 9'h019, A_TXSTA = 9'h098, A_SPBRG = 9'h099;

  logic       clk = 1'b0, rst = 1'b0;
  logic [8:0] addr = 9'h000;
  logic [7:0] data_in = 8'h00;
  logic       wr_en = 1'b0;
  logic [7:0] data_out;
  logic       interrupt_strobe, tx;
  int checks = 0, errors = 0;

  usart_tx_peripheral dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .wr_en(wr_en),
    .data_out(data_out), .interrupt_strobe(interrupt_strobe), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr = a; data_in = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; addr = 9'h000;
  endtask

  task automatic rd(input string tag, input logic [8:0] a, input logic [7:0] exp);
    logic [8:0] sv;
    sv = addr; addr = a; #1;
    chk(tag, data_out, exp);
    addr = sv;
  endtask

  // Reference: a frame is start(0), 8 data LSB-first, optional ninth, stop(1); each bit held T clocks.
  // Call right after the TXREG write edge's idle sample; the transfer strobe lands on the first frame sample.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic b9,
                              input logic nine, input int T);
    logic [10:0] fr;
    int n, good, stray;
    logic first;
    fr = nine ? {1'b1, b9, d, 1'b0} : {1'b0, 1'b1, d, 1'b0};
    n = nine ? 11 : 10;
    stray = 0; first = 1'b0;
    for (int i = 0; i < n; i++) begin
      good = 0;
      for (int j = 0; j < T; j++) begin
        @(negedge clk);
        if (tx === fr[i]) good++;
        if (interrupt_strobe === 1'b1) begin
          if (i == 0 && j == 0) first = 1'b1;
          else stray++;
        end
      end
      chk($sformatf("%s bit%0d", tag, i), good, T);
    end
    chk({tag, " strobe"}, first, 1'b1);
    chk({tag, " stray strobe"}, stray, 0);
  endtask

  task automatic watch_idle(input string tag, input int n);
    int good, stb;
    good = 0; stb = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx === 1'b1) good++;
      if (interrupt_strobe === 1'b1) stb++;
    end
    chk({tag, " tx high"}, good, n);
    chk({tag, " no strobe"}, stb, 0);
  endtask

  task automatic pre_idle(input string tag);
    @(negedge clk);
    chk({tag, " pre tx"}, tx, 1'b1);
    chk({tag, " pre strobe"}, interrupt_strobe, 1'b0);
  endtask

  initial begin
    logic [7:0] sp, d, txsta;
    logic bh, n9, b9;
    #23 rst = 1'b1;

    // reset state
    rd("rst TXSTA", A_TXSTA, 8'h02);
    rd("rst SPBRG", A_SPBRG, 8'h00);
    rd("rst unmapped", 9'h020, 8'h00);
    rd("rst TXREG", A_TXREG, 8'h00);
    chk("rst tx", tx, 1'b1);
    chk("rst strobe", interrupt_strobe, 1'b0);

    // 8N1 at 16 clk/bit, enable strobe
    wr(A_SPBRG, 8'h00);
    wr(A_TXSTA, 8'h24);
    @(negedge clk); chk("en strobe", interrupt_strobe, 1'b1);
    @(negedge clk); chk("en strobe width", interrupt_strobe, 1'b0);
    wr(A_TXREG, 8'h55);
    rd("trmt before xfer", A_TXSTA, 8'h26);
    pre_idle("f55");
    expect_frame("f55", 8'h55, 1'b0, 1'b0, 16);
    @(negedge clk);
    chk("f55 post tx", tx, 1'b1);
    rd("f55 trmt", A_TXSTA, 8'h26);

    // back-to-back at 128 clk/bit: second write during first start bit
    wr(A_SPBRG, 8'h01);
    wr(A_TXSTA, 8'h20);
    wr(A_TXREG, 8'hA3);
    pre_idle("fA3");
    fork
      expect_frame("fA3", 8'hA3, 1'b0, 1'b0, 128);
      begin
        repeat (10) @(posedge clk);
        wr(A_TXREG, 8'h0F);
      end
    join
    expect_frame("f0F", 8'h0F, 1'b0, 1'b0, 128);
    watch_idle("after 0F", 20);

    // ninth bit configuration
    wr(A_SPBRG, 8'h00);
    wr(A_TXSTA, 8'h65);
`ifdef USART_TX_NINTH_BIT_EN
    rd("TXSTA tx9 rb", A_TXSTA, 8'h67);
    wr(A_TXREG, 8'h00);
    pre_idle("f9");
    expect_frame("f9", 8'h00, 1'b1, 1'b1, 16);
`else
    rd("TXSTA tx9 rb", A_TXSTA, 8'h26);
    wr(A_TXREG, 8'h00);
    pre_idle("f9");
    expect_frame("f9", 8'h00, 1'b0, 1'b0, 16);
`endif
    watch_idle("after f9", 5);

    // random frames
    for (int k = 0; k < 6; k++) begin
      sp = 8'($urandom_range(0, 2));
      bh = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      b9 = 1'($urandom_range(0, 1));
`ifdef USART_TX_NINTH_BIT_EN
      n9 = 1'($urandom_range(0, 1));
`else
      n9 = 1'b0;
`endif
      txsta = {1'b0, n9, 1'b1, 2'b00, bh, 1'b0, b9};
      wr(A_SPBRG, sp);
      wr(A_TXSTA, txsta);
      rd($sformatf("rnd%0d SPBRG", k), A_SPBRG, sp);
      wr(A_TXREG, d);
      pre_idle($sformatf("rnd%0d", k));
      expect_frame($sformatf("rnd%0d", k), d, b9, n9, (bh ? 16 : 64) * (int'(sp) + 1));
    end

    // disable mid-DATA
    wr(A_SPBRG, 8'h00);
    wr(A_TXSTA, 8'h24);
    wr(A_TXREG, 8'hC3);
    repeat (40) @(posedge clk);
    wr(A_TXSTA, 8'h04);
    rd("dis trmt", A_TXSTA, 8'h06);
    @(negedge clk);
    chk("dis tx", tx, 1'b1);
    chk("dis strobe", interrupt_strobe, 1'b0);
    watch_idle("dis hold", 200);
    wr(A_TXREG, 8'h5A);
    watch_idle("dis write", 200);
    wr(A_TXSTA, 8'h24);
    @(negedge clk); chk("reen strobe", interrupt_strobe, 1'b1);
    watch_idle("reen empty", 200);

    // async reset mid-frame
    wr(A_SPBRG, 8'h00);
    wr(A_TXREG, 8'hF0);
    repeat (50) @(posedge clk);
    #3;
    chk("pre-rst tx low", tx, 1'b0);
    rst = 1'b0; #1;
    chk("rst mid tx", tx, 1'b1);
    chk("rst mid strobe", interrupt_strobe, 1'b0);
    rd("rst mid TXSTA", A_TXSTA, 8'h02);
    rd("rst mid SPBRG", A_SPBRG, 8'h00);
    @(posedge clk); #3;
    rst = 1'b1;
    rd("post rst TXSTA", A_TXSTA, 8'h02);
    watch_idle("post rst", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/usart_tx_peripheral.md
# usart_tx_peripheral

Memory-mapped asynchronous serial transmitter that sits on the core's external peripheral bus as a responder. It decodes TXREG, TXSTA and SPBRG, buffers one byte behind a shift register, and serialises 8N1 or, optionally, 9N1 frames onto `tx`. It pulses a one-cycle interrupt strobe each time the holding register empties, for PIR1 bit 4 (TXIF).

## Interface
- `TXREG_ADDR`, 9'h019, TXREG address (write-only; reads return 8'h00)
- `TXSTA_ADDR`, 9'h098, TXSTA address
- `SPBRG_ADDR`, 9'h099, SPBRG address
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `addr`  in  9  register-file address from the core
- `data_in`  in  8  write data from the core (ALU result)
- `wr_en`  in  1  write strobe, one `clk` per write, qualified by `addr`
- `data_out`  out  8  read data, combinational from `addr`; 8'h00 when no address matches, so outputs can be OR-combined
- `interrupt_strobe`  out  1  one-cycle pulse to PIR1 bit 4
- `tx`  out  1  serial line, idle high

## Operation
- TXSTA layout:
  - bit 6: TX9, R/W
  - bit 5: TXEN, R/W
  - bit 2: BRGH, R/W
  - bit 1: TRMT, read-only, 1 when the FSM is IDLE
  - bit 0: TX9D, R/W
  - bits 7, 4, 3 read 0; writes to TRMT are ignored.
- SPBRG: 8-bit R/W.
- Reset values: TXSTA 8'h02 (TRMT=1), SPBRG 8'h00, holding register empty, FSM IDLE, `tx`=1, `interrupt_strobe`=0.
- Baud generator:
  - An 8-bit down-counter reloads from SPBRG and emits a tick on reaching 0.
  - A sub-counter counts 16 ticks (BRGH=1) or 64 ticks (BRGH=0) per bit time.
  - Bit time is 16·(SPBRG+1) clocks (BRGH=1) or 64·(SPBRG+1) clocks (BRGH=0).
  - Both counters restart at every bit boundary.
  - SPBRG/BRGH writes take effect at the next bit boundary.
- Holding register (TXREG) has a full flag.
  - Writing TXREG with TXEN=1 loads the data and sets full.
  - Writes with TXEN=0 are discarded.
  - Writing while full overwrites the byte; the old byte is lost and no strobe is issued.
- FSM states: IDLE, START, DATA, NINTH, STOP.
  - IDLE: if full and TXEN, transfer holding to the TSR, clear full, pulse `interrupt_strobe`, go to START.
  - START: `tx`=0 for one bit time, then DATA.
  - DATA: shift 8 bits LSB first, one bit time each. Then NINTH if TX9, else STOP.
  - NINTH: `tx`=TX9D (latched at transfer) for one bit time, then STOP.
  - STOP: `tx`=1 for one bit time. At the end, if full, transfer immediately and go to START with no idle gap (strobe pulses); else go to IDLE.
- TXEN 1→0 at any point:
  - FSM goes to IDLE and `tx`=1 on the next edge.
  - full is cleared, counters are reset, no strobe.
- TXEN 0→1: one-cycle `interrupt_strobe` pulse (holding empty).
- Simultaneous TXREG write and end-of-STOP: the new byte is loaded into holding. Transfer occurs next cycle from IDLE, giving a one-clock idle gap.
- Reset asserted mid-frame: all state returns to reset values asynchronously; `tx`=1 immediately.

## Timing
- Write to TXREG at edge N while IDLE:
  - full=1 after N.
  - Transfer and `interrupt_strobe`=1 in the cycle after edge N+1.
  - `tx` falls after edge N+1.
  - TRMT reads 0 from cycle N+1.
- Frame length:
  - 10 bit times (8N1) or 11 bit times (TX9=1).
  - The next start bit follows the stop bit with zero gap when full.
- `data_out` is combinational; same-cycle read of a register just written returns the old value.
- `interrupt_strobe` is exactly one cycle wide, registered.

## Configuration
- `USART_TX_NINTH_BIT_EN` defined: TX9/TX9D are implemented and the NINTH state is reachable.
- Not defined:
  - TX9/TX9D read 0 and writes to them are ignored.
  - NINTH state is absent; frames are always 10 bits.

## Test plan
- Reset, then read: TXSTA=8'h02, SPBRG=8'h00, `tx`=1, unmapped addr 9'h020 → `data_out`=8'h00.
- SPBRG=0, BRGH=1, TXEN=1 (one strobe observed), write TXREG=8'h55 → one strobe one cycle later; `tx` = 0 for 16 clk, then 1,0,1,0,1,0,1,0 (16 clk each), then 1 for 16 clk; total 160 clk; TRMT returns to 1.
- SPBRG=1, BRGH=0, write 8'hA3 then 8'h0F during its start bit → bit time 128 clk; two strobes; second frame's start bit begins exactly at first frame's stop end.
- With `USART_TX_NINTH_BIT_EN`, TX9=1, TX9D=1, write 8'h00 → 11-bit frame: 0, eight 0s, 1, 1.
- Mid-DATA, write TXSTA clearing TXEN → `tx`=1 next edge, TRMT=1, no strobe; write TXREG with TXEN=0 → no transmission.
- Assert `rst` mid-frame for 1 clk → `tx`=1 asynchronously, all registers at reset values.
